// File: rtl/obi_timer.sv
// OBI secondary timer: prescaled 32-bit up-counter with compare-match,
// optional auto-reload and a registered level interrupt.
module obi_timer #(
    parameter int unsigned PRESCALE_W  = 16,
    parameter logic [31:0] COMPARE_RST = 32'hFFFF_FFFF
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    output logic        gnt_o,
    input  logic [31:0] addr_i,
    input  logic        we_i,
    input  logic [3:0]  be_i,
    input  logic [31:0] wdata_i,
    output logic        rvalid_o,
    output logic [31:0] rdata_o,
    output logic        irq_o
);

    localparam int unsigned DATA_W = 32;
    localparam int unsigned CTRL_W = 3;

    localparam logic [2:0] ADDR_CTRL     = 3'd0;
    localparam logic [2:0] ADDR_STATUS   = 3'd1;
    localparam logic [2:0] ADDR_COUNT    = 3'd2;
    localparam logic [2:0] ADDR_COMPARE  = 3'd3;
    localparam logic [2:0] ADDR_PRESCALE = 3'd4;

    logic [CTRL_W-1:0]     ctrl_q, ctrl_d;
    logic                  match_q, match_d;
    logic [DATA_W-1:0]     count_q, count_d;
    logic [DATA_W-1:0]     compare_q, compare_d;
    logic [PRESCALE_W-1:0] prescale_q, prescale_d;
    logic [PRESCALE_W-1:0] pcnt_q, pcnt_d;
    logic                  rvalid_q, rvalid_d;
    logic [DATA_W-1:0]     rdata_q, rdata_d;
    logic                  irq_q, irq_d;

    logic                  accept;
    logic                  wr_en;
    logic [2:0]            reg_sel;
    logic [DATA_W-1:0]     be_mask;
    logic [PRESCALE_W-1:0] prescale_mask;
    logic                  tick;
    logic                  match_hit;
    logic                  count_wr;
    logic [DATA_W-1:0]     read_val;
    logic                  unused_addr;

    logic ctrl_en, ctrl_auto_reload, ctrl_irq_en;

    assign ctrl_en          = ctrl_q[0];
    assign ctrl_auto_reload = ctrl_q[1];
    assign ctrl_irq_en      = ctrl_q[2];

    // The block never stalls, so grant simply follows request.
    assign gnt_o   = req_i;
    assign accept  = req_i & gnt_o;
    assign wr_en   = accept & we_i;
    assign reg_sel = addr_i[4:2];

    assign be_mask       = {{8{be_i[3]}}, {8{be_i[2]}}, {8{be_i[1]}}, {8{be_i[0]}}};
    assign prescale_mask = be_mask[PRESCALE_W-1:0];
    assign unused_addr   = ^{addr_i[31:5], addr_i[1:0]};

    // Prescaler; a write that leaves EN low also restarts the prescale count.
    always_comb begin
        tick   = 1'b0;
        pcnt_d = pcnt_q;
        if (ctrl_en) begin
            if (pcnt_q == prescale_q) begin
                tick   = 1'b1;
                pcnt_d = '0;
            end else begin
                pcnt_d = pcnt_q + PRESCALE_W'(1);
            end
        end
        if (wr_en && (reg_sel == ADDR_CTRL) && be_i[0] && !wdata_i[0]) begin
            pcnt_d = '0;
        end
    end

    // Counter: a bus write to COUNT overrides the tick for that cycle.
    always_comb begin
        count_d   = count_q;
        match_hit = 1'b0;
        count_wr  = wr_en && (reg_sel == ADDR_COUNT) && (|be_i);
        if (count_wr) begin
            count_d = (count_q & ~be_mask) | (wdata_i & be_mask);
        end else if (tick) begin
            if (count_q == compare_q) begin
                match_hit = 1'b1;
                count_d   = ctrl_auto_reload ? '0 : count_q + DATA_W'(1);
            end else begin
                count_d = count_q + DATA_W'(1);
            end
        end
    end

    // Configuration registers and MATCH (set beats a simultaneous clear).
    always_comb begin
        ctrl_d     = ctrl_q;
        compare_d  = compare_q;
        prescale_d = prescale_q;
        match_d    = match_q;
        if (wr_en) begin
            case (reg_sel)
                ADDR_CTRL: begin
                    if (be_i[0]) ctrl_d = wdata_i[CTRL_W-1:0];
                end
                ADDR_STATUS: begin
                    if (be_i[0] && wdata_i[0]) match_d = 1'b0;
                end
                ADDR_COMPARE: begin
                    compare_d = (compare_q & ~be_mask) | (wdata_i & be_mask);
                end
                ADDR_PRESCALE: begin
                    prescale_d = (prescale_q & ~prescale_mask)
                               | (wdata_i[PRESCALE_W-1:0] & prescale_mask);
                end
                default: ;
            endcase
        end
        if (match_hit) match_d = 1'b1;
    end

    always_comb begin
        read_val = '0;
        case (reg_sel)
            ADDR_CTRL:     read_val = {{(DATA_W-CTRL_W){1'b0}}, ctrl_q};
            ADDR_STATUS:   read_val = {{(DATA_W-1){1'b0}}, match_q};
            ADDR_COUNT:    read_val = count_q;
            ADDR_COMPARE:  read_val = compare_q;
            ADDR_PRESCALE: read_val = DATA_W'(prescale_q);
            default:       read_val = '0;
        endcase
    end

    // Response and interrupt, all registered.
    always_comb begin
        rvalid_d = accept;
        rdata_d  = (accept && !we_i) ? read_val : '0;
        irq_d    = match_q & ctrl_irq_en;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ctrl_q     <= '0;
            match_q    <= 1'b0;
            count_q    <= '0;
            compare_q  <= COMPARE_RST;
            prescale_q <= '0;
            pcnt_q     <= '0;
            rvalid_q   <= 1'b0;
            rdata_q    <= '0;
            irq_q      <= 1'b0;
        end else begin
            ctrl_q     <= ctrl_d;
            match_q    <= match_d;
            count_q    <= count_d;
            compare_q  <= compare_d;
            prescale_q <= prescale_d;
            pcnt_q     <= pcnt_d;
            rvalid_q   <= rvalid_d;
            rdata_q    <= rdata_d;
            irq_q      <= irq_d;
        end
    end

    assign rvalid_o = rvalid_q;
    assign rdata_o  = rdata_q;
    assign irq_o    = irq_q;

endmodule

// File: tb/tb_obi_timer.sv
// Testbench for obi_timer: register-array reference model feeding a response
// scoreboard, directed scenarios with constant expectations, then random traffic.
module tb_obi_timer;

    localparam int unsigned PW    = 16;
    localparam logic [31:0] PMASK = 32'h0000_FFFF;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        req_i;
    logic        gnt_o;
    logic [31:0] addr_i;
    logic        we_i;
    logic [3:0]  be_i;
    logic [31:0] wdata_i;
    logic        rvalid_o;
    logic [31:0] rdata_o;
    logic        irq_o;

    int total = 0;
    int bad   = 0;

    typedef struct {
        int unsigned stamp;
        logic [31:0] data;
    } resp_t;

    resp_t       sb[$];
    logic [31:0] mregs [0:7];
    int unsigned mpcnt;
    logic        exp_irq;
    int unsigned cyc = 0;

    obi_timer #(.PRESCALE_W(PW), .COMPARE_RST(32'hFFFF_FFFF)) dut (
        .clk_i    (clk_i),
        .rst_i    (rst_i),
        .req_i    (req_i),
        .gnt_o    (gnt_o),
        .addr_i   (addr_i),
        .we_i     (we_i),
        .be_i     (be_i),
        .wdata_i  (wdata_i),
        .rvalid_o (rvalid_o),
        .rdata_o  (rdata_o),
        .irq_o    (irq_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] byte_mask(input logic [3:0] b);
        logic [31:0] m = '0;
        for (int k = 0; k < 4; k++) if (b[k]) m[k*8 +: 8] = 8'hFF;
        return m;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 8; k++) mregs[k] = '0;
        mregs[3] = 32'hFFFF_FFFF;
        mpcnt    = 0;
        exp_irq  = 1'b0;
        sb.delete();
    endtask

    // Reference model: registers held as an address-indexed array, updated per edge.
    task automatic model_step();
        logic [31:0] nregs [0:7];
        logic [31:0] msk, wmask;
        int unsigned npcnt;
        int          a;
        logic        tick, set_match, wr, cnt_wr;
        resp_t       r;
        cyc++;
        a     = int'(addr_i[4:2]);
        tick  = mregs[0][0] && (mpcnt == mregs[4]);
        nregs = mregs;
        npcnt = mpcnt;
        if (req_i) begin
            r.stamp = cyc;
            r.data  = we_i ? 32'h0 : mregs[a];
            sb.push_back(r);
        end
        if (mregs[0][0]) npcnt = tick ? 0 : ((mpcnt + 1) & PMASK);
        wr        = req_i && we_i;
        msk       = byte_mask(be_i);
        cnt_wr    = wr && (a == 2) && (be_i != 4'h0);
        set_match = 1'b0;
        if (tick && !cnt_wr) begin
            if (mregs[2] == mregs[3]) begin
                set_match = 1'b1;
                nregs[2]  = mregs[0][1] ? 32'h0 : mregs[2] + 32'd1;
            end else begin
                nregs[2] = mregs[2] + 32'd1;
            end
        end
        if (wr) begin
            wmask = 32'h0;
            case (a)
                0: wmask = msk & 32'h7;
                2, 3: wmask = msk;
                4: wmask = msk & PMASK;
                default: wmask = 32'h0;
            endcase
            if (wmask != 0) nregs[a] = (mregs[a] & ~wmask) | (wdata_i & wmask);
            if (a == 0 && be_i[0] && !wdata_i[0]) npcnt = 0;
            if (a == 1 && be_i[0] && wdata_i[0]) nregs[1] = 32'h0;
        end
        if (set_match) nregs[1] = 32'h1;
        exp_irq = mregs[1][0] & mregs[0][2];
        mregs   = nregs;
        mpcnt   = npcnt;
    endtask

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) model_reset();
        else       model_step();
    end

    // Monitor: every cycle compares irq and the response channel with the scoreboard.
    always @(negedge clk_i) begin
        if (!rst_i) begin
            check("irq", 32'(irq_o), 32'(exp_irq));
            if (sb.size() > 0 && sb[0].stamp == cyc) begin
                check("rvalid", 32'(rvalid_o), 32'h1);
                check("rdata", rdata_o, sb[0].data);
                void'(sb.pop_front());
            end else begin
                check("idle_rvalid", 32'(rvalid_o), 32'h0);
                check("idle_rdata", rdata_o, 32'h0);
            end
        end
    end

    task automatic bus(input logic [31:0] a, input logic w, input logic [3:0] b, input logic [31:0] d);
        req_i   = 1'b1;
        addr_i  = a;
        we_i    = w;
        be_i    = b;
        wdata_i = d;
        #1 check("gnt", 32'(gnt_o), 32'h1);
        @(negedge clk_i);
        req_i   = 1'b0;
        we_i    = 1'b0;
        be_i    = 4'h0;
        wdata_i = 32'h0;
        addr_i  = 32'h0;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        bus(a, 1'b1, 4'hF, d);
    endtask

    task automatic rd(input logic [31:0] a, output logic [31:0] v);
        bus(a, 1'b0, 4'hF, 32'h0);
        v = rdata_o;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        logic [31:0] seq [0:29];
        int          last_chg, n_chg;
        logic        ok_step, ok_gap, wrapped, seen;

        rst_i = 1'b1; req_i = 1'b0; we_i = 1'b0; addr_i = '0; be_i = '0; wdata_i = '0;
        repeat (2) @(negedge clk_i);
        check("rst_gnt", 32'(gnt_o), 32'h0);
        check("rst_rvalid", 32'(rvalid_o), 32'h0);
        check("rst_rdata", rdata_o, 32'h0);
        check("rst_irq", 32'(irq_o), 32'h0);
        rst_i = 1'b0;
        @(negedge clk_i);

        rd(32'h0C, v); check("compare_rst", v, 32'hFFFF_FFFF);
        rd(32'h14, v); check("unmapped_rd", v, 32'h0);

        bus(32'h08, 1'b1, 4'b0010, 32'h1234_5678);
        rd(32'h08, v); check("be_partial", v, 32'h0000_5600);
        bus(32'h08, 1'b1, 4'b0000, 32'hFFFF_FFFF);
        check("be0_rvalid", 32'(rvalid_o), 32'h1);
        check("be0_rdata", rdata_o, 32'h0);
        rd(32'h08, v); check("be0_nochange", v, 32'h0000_5600);

        // Prescale 3, compare 5, auto-reload: count steps every 4 cycles, 0..5 then 0.
        wr(32'h10, 32'd3); wr(32'h0C, 32'd5); wr(32'h08, 32'd0); wr(32'h00, 32'h3);
        for (int i = 0; i < 30; i++) begin
            rd(32'h08, v);
            seq[i] = v;
        end
        check("seq_first", seq[0], 32'h0);
        last_chg = -1; n_chg = 0; ok_step = 1'b1; ok_gap = 1'b1; wrapped = 1'b0;
        for (int i = 1; i < 30; i++) begin
            if (seq[i] != seq[i-1]) begin
                n_chg++;
                if (seq[i-1] == 32'd5 && seq[i] == 32'd0) wrapped = 1'b1;
                else if (!(seq[i] == seq[i-1] + 32'd1 && seq[i] <= 32'd5)) ok_step = 1'b0;
                if (last_chg >= 0 && (i - last_chg) != 4) ok_gap = 1'b0;
                last_chg = i;
            end
        end
        check("seq_step", 32'(ok_step), 32'h1);
        check("seq_gap", 32'(ok_gap), 32'h1);
        check("seq_wrap", 32'(wrapped), 32'h1);
        check("seq_changes", 32'(n_chg), 32'd7);
        rd(32'h04, v); check("match_set", v, 32'h1);
        check("irq_masked", 32'(irq_o), 32'h0);

        // Interrupt on match, then clear via W1C.
        wr(32'h00, 32'h0); wr(32'h04, 32'h1); wr(32'h08, 32'h0);
        wr(32'h0C, 32'h2); wr(32'h10, 32'h0); wr(32'h00, 32'h5);
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            @(negedge clk_i);
            if (irq_o) seen = 1'b1;
        end
        check("irq_seen", 32'(seen), 32'h1);
        wr(32'h04, 32'h1);
        check("irq_w1c_lag", 32'(irq_o), 32'h1);
        @(negedge clk_i);
        check("irq_cleared", 32'(irq_o), 32'h0);
        rd(32'h04, v); check("match_cleared", v, 32'h0);

        // W1C landing on the match edge: set wins.
        wr(32'h00, 32'h0); wr(32'h04, 32'h1); wr(32'h08, 32'h0); wr(32'h0C, 32'h3);
        wr(32'h00, 32'h5);
        repeat (3) @(negedge clk_i);
        wr(32'h04, 32'h1);
        rd(32'h04, v); check("w1c_vs_set", v, 32'h1);

        // 32-bit wrap without auto-reload; match only at 0x10.
        wr(32'h00, 32'h0); wr(32'h04, 32'h1); wr(32'h08, 32'hFFFF_FFFE);
        wr(32'h10, 32'h0); wr(32'h0C, 32'h10); wr(32'h00, 32'h1);
        rd(32'h08, v); check("wrap_0", v, 32'hFFFF_FFFE);
        rd(32'h08, v); check("wrap_1", v, 32'hFFFF_FFFF);
        rd(32'h08, v); check("wrap_2", v, 32'h0);
        rd(32'h04, v); check("wrap_nomatch", v, 32'h0);
        repeat (20) @(negedge clk_i);
        rd(32'h04, v); check("wrap_match", v, 32'h1);
        wr(32'h08, 32'hABCD_0000);
        rd(32'h08, v); check("count_wr_on_tick", v, 32'hABCD_0000);

        // Reset between accept and response.
        wr(32'h00, 32'h7); wr(32'h0C, 32'h55); wr(32'h10, 32'h9);
        req_i = 1'b1; addr_i = 32'h0C; we_i = 1'b0; be_i = 4'hF;
        @(posedge clk_i);
        #1 rst_i = 1'b1;
        @(negedge clk_i);
        req_i = 1'b0; addr_i = '0; be_i = '0;
        check("rst_drop_rvalid", 32'(rvalid_o), 32'h0);
        @(negedge clk_i);
        rst_i = 1'b0;
        @(negedge clk_i);
        check("rst_rvalid_after", 32'(rvalid_o), 32'h0);
        rd(32'h00, v); check("rst_ctrl", v, 32'h0);
        rd(32'h04, v); check("rst_status", v, 32'h0);
        rd(32'h08, v); check("rst_count", v, 32'h0);
        rd(32'h0C, v); check("rst_compare", v, 32'hFFFF_FFFF);
        rd(32'h10, v); check("rst_prescale", v, 32'h0);
        check("rst_irq_after", 32'(irq_o), 32'h0);

        // Random traffic against the reference model.
        for (int i = 0; i < 500; i++) begin
            if ($urandom_range(0, 3) != 0) begin
                bus($urandom, 1'($urandom_range(0, 1)), 4'($urandom),
                    ($urandom_range(0, 3) == 0) ? $urandom : 32'($urandom_range(0, 12)));
            end else begin
                @(negedge clk_i);
            end
        end

        repeat (3) @(negedge clk_i);
        check("sb_drained", 32'(sb.size()), 32'h0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
